// File: rtl/branch_resolve_queue_if.sv
// rtl/branch_resolve_queue_if.sv - allocation, resolution and commit signals of the branch resolve queue
interface branch_resolve_queue_if #(
  parameter int DEPTH = 8
);
  localparam int TAGW = $clog2(DEPTH);

  logic            alloc_valid_i;
  logic            alloc_ready_o;
  logic [31:0]     alloc_pc_i;
  logic            alloc_pred_taken_i;
  logic [31:0]     alloc_pred_target_i;
  logic [TAGW-1:0] alloc_tag_o;
  logic            res_valid_i;
  logic [TAGW-1:0] res_tag_i;
  logic            res_taken_i;
  logic [31:0]     res_target_i;
  logic            ex_br_valid_o;
  logic [31:0]     ex_br_instr_addr_o;
  logic            ex_br_taken_o;
  logic            flush_o;
  logic [31:0]     redirect_pc_o;
  logic [TAGW:0]   count_o;

  modport slave (
    input  alloc_valid_i, alloc_pc_i, alloc_pred_taken_i, alloc_pred_target_i,
    input  res_valid_i, res_tag_i, res_taken_i, res_target_i,
    output alloc_ready_o, alloc_tag_o, ex_br_valid_o, ex_br_instr_addr_o,
    output ex_br_taken_o, flush_o, redirect_pc_o, count_o
  );

  modport master (
    output alloc_valid_i, alloc_pc_i, alloc_pred_taken_i, alloc_pred_target_i,
    output res_valid_i, res_tag_i, res_taken_i, res_target_i,
    input  alloc_ready_o, alloc_tag_o, ex_br_valid_o, ex_br_instr_addr_o,
    input  ex_br_taken_o, flush_o, redirect_pc_o, count_o
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch resolve queue with predictor update and mispredict flush
module branch_resolve_queue #(
  parameter int DEPTH = 8
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  branch_resolve_queue_if.slave bus
);
  localparam int TAGW = $clog2(DEPTH);
  localparam logic [TAGW:0] DEPTH_C = (TAGW+1)'(DEPTH);

  logic [DEPTH-1:0] valid_q, valid_d, resolved_q, resolved_d;
  logic [DEPTH-1:0] pred_taken_q, pred_taken_d, act_taken_q, act_taken_d;
  logic [31:0]      pc_q [DEPTH];
  logic [31:0]      pc_d [DEPTH];
  logic [31:0]      pred_target_q [DEPTH];
  logic [31:0]      pred_target_d [DEPTH];
  logic [31:0]      act_target_q [DEPTH];
  logic [31:0]      act_target_d [DEPTH];
  logic [TAGW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAGW:0]    count_q, count_d;
  logic             ex_valid_q, ex_valid_d, ex_taken_q, ex_taken_d;
  logic [31:0]      ex_addr_q, ex_addr_d, redirect_q, redirect_d;
  logic             flush_q, flush_d;

  logic alloc_ready, alloc_fire, res_hit, commit, mispredict;

  always_comb begin
    valid_d      = valid_q;
    resolved_d   = resolved_q;
    pred_taken_d = pred_taken_q;
    act_taken_d  = act_taken_q;
    pc_d         = pc_q;
    pred_target_d = pred_target_q;
    act_target_d = act_target_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    ex_valid_d   = 1'b0;
    ex_addr_d    = ex_addr_q;
    ex_taken_d   = ex_taken_q;
    flush_d      = 1'b0;
    redirect_d   = redirect_q;

    // Commit only frees space on the following cycle, so readiness looks at registered count.
    alloc_ready = (count_q < DEPTH_C) & ~flush_q;
    alloc_fire  = bus.alloc_valid_i & alloc_ready;
    res_hit     = bus.res_valid_i & valid_q[bus.res_tag_i] & ~resolved_q[bus.res_tag_i];
    commit      = valid_q[head_q] & resolved_q[head_q];
    mispredict  = (act_taken_q[head_q] != pred_taken_q[head_q]) |
                  (act_taken_q[head_q] & (act_target_q[head_q] != pred_target_q[head_q]));

    if (alloc_fire) begin
      valid_d[tail_q]       = 1'b1;
      resolved_d[tail_q]    = 1'b0;
      pc_d[tail_q]          = bus.alloc_pc_i;
      pred_taken_d[tail_q]  = bus.alloc_pred_taken_i;
      pred_target_d[tail_q] = bus.alloc_pred_target_i;
      tail_d                = tail_q + 1'b1;
    end

    if (res_hit) begin
      resolved_d[bus.res_tag_i]   = 1'b1;
      act_taken_d[bus.res_tag_i]  = bus.res_taken_i;
      act_target_d[bus.res_tag_i] = bus.res_target_i;
    end

    if (commit) begin
      ex_valid_d = 1'b1;
      ex_addr_d  = pc_q[head_q];
      ex_taken_d = act_taken_q[head_q];
      if (mispredict) begin
        // Everything younger is on the wrong path; this overrides any same-cycle alloc/resolve.
        flush_d    = 1'b1;
        redirect_d = act_taken_q[head_q] ? act_target_q[head_q] : pc_q[head_q] + 32'd4;
        valid_d    = '0;
        resolved_d = '0;
        head_d     = head_q + 1'b1;
        tail_d     = head_q + 1'b1;
      end else begin
        valid_d[head_q]    = 1'b0;
        resolved_d[head_q] = 1'b0;
        head_d             = head_q + 1'b1;
      end
    end

    if (commit && mispredict) begin
      count_d = '0;
    end else if (alloc_fire && !commit) begin
      count_d = count_q + 1'b1;
    end else if (!alloc_fire && commit) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= '0;
      resolved_q   <= '0;
      pred_taken_q <= '0;
      act_taken_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]          <= '0;
        pred_target_q[i] <= '0;
        act_target_q[i]  <= '0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ex_valid_q <= 1'b0;
      ex_addr_q  <= '0;
      ex_taken_q <= 1'b0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      valid_q       <= valid_d;
      resolved_q    <= resolved_d;
      pred_taken_q  <= pred_taken_d;
      act_taken_q   <= act_taken_d;
      pc_q          <= pc_d;
      pred_target_q <= pred_target_d;
      act_target_q  <= act_target_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      ex_valid_q    <= ex_valid_d;
      ex_addr_q     <= ex_addr_d;
      ex_taken_q    <= ex_taken_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
    end
  end

  assign bus.alloc_ready_o      = alloc_ready;
  assign bus.alloc_tag_o        = tail_q;
  assign bus.ex_br_valid_o      = ex_valid_q;
  assign bus.ex_br_instr_addr_o = ex_addr_q;
  assign bus.ex_br_taken_o      = ex_taken_q;
  assign bus.flush_o            = flush_q;
  assign bus.redirect_pc_o      = redirect_q;
  assign bus.count_o            = count_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - directed scoreboard bench for branch_resolve_queue
module tb_branch_resolve_queue;
  localparam int DEPTH = 8;
  localparam int TAGW  = 3;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  branch_resolve_queue_if #(.DEPTH(DEPTH)) bus ();
  branch_resolve_queue #(.DEPTH(DEPTH)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        flush;
    logic [31:0] redir;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad   = 0;

  logic            m_valid [DEPTH];
  logic            m_res   [DEPTH];
  logic [31:0]     m_pc    [DEPTH];
  logic            m_pt    [DEPTH];
  logic [31:0]     m_ptg   [DEPTH];
  logic            m_at    [DEPTH];
  logic [31:0]     m_atg   [DEPTH];
  logic [TAGW-1:0] m_head, m_tail;
  int              m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      if (bus.ex_br_valid_o === 1'b1) begin
        total++;
        assert (sb.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_update observed addr=0x%0h expected no update", bus.ex_br_instr_addr_o);
        end
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("update_addr", bus.ex_br_instr_addr_o, mon_e.pc);
          check("update_taken", bus.ex_br_taken_o, mon_e.taken);
          check("update_flush", bus.flush_o, mon_e.flush);
          if (mon_e.flush) check("redirect_pc", bus.redirect_pc_o, mon_e.redir);
        end
      end else if (bus.flush_o !== 1'b0) begin
        check("flush_without_update", bus.flush_o, 0);
      end
    end
  end

  task cyc();
    @(posedge clk_i);
    #1;
  endtask

  task idle(input int n);
    repeat (n) cyc();
  endtask

  task model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0;
      m_res[i]   = 1'b0;
    end
    m_head  = '0;
    m_tail  = '0;
    m_count = 0;
  endtask

  task automatic drain();
    logic done;
    logic mis;
    exp_t e;
    done = 1'b0;
    while (!done && m_valid[m_head] && m_res[m_head]) begin
      mis = (m_at[m_head] != m_pt[m_head]) || (m_at[m_head] && (m_atg[m_head] != m_ptg[m_head]));
      e.pc    = m_pc[m_head];
      e.taken = m_at[m_head];
      e.flush = mis;
      e.redir = m_at[m_head] ? m_atg[m_head] : m_pc[m_head] + 32'd4;
      sb.push_back(e);
      if (mis) begin
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_head  = m_head + 1'b1;
        m_tail  = m_head;
        m_count = 0;
        done    = 1'b1;
      end else begin
        m_valid[m_head] = 1'b0;
        m_head  = m_head + 1'b1;
        m_count = m_count - 1;
      end
    end
  endtask

  task automatic alloc_ok(input logic [31:0] pc, input logic pt, input logic [31:0] tg);
    check("alloc_ready", bus.alloc_ready_o, 1);
    check("alloc_tag", bus.alloc_tag_o, m_tail);
    bus.alloc_valid_i       = 1'b1;
    bus.alloc_pc_i          = pc;
    bus.alloc_pred_taken_i  = pt;
    bus.alloc_pred_target_i = tg;
    cyc();
    bus.alloc_valid_i = 1'b0;
    m_valid[m_tail] = 1'b1;
    m_res[m_tail]   = 1'b0;
    m_pc[m_tail]    = pc;
    m_pt[m_tail]    = pt;
    m_ptg[m_tail]   = tg;
    m_tail  = m_tail + 1'b1;
    m_count = m_count + 1;
  endtask

  task automatic resolve(input logic [TAGW-1:0] tag, input logic t, input logic [31:0] tg);
    bus.res_valid_i  = 1'b1;
    bus.res_tag_i    = tag;
    bus.res_taken_i  = t;
    bus.res_target_i = tg;
    cyc();
    bus.res_valid_i = 1'b0;
    if (m_valid[tag] && !m_res[tag]) begin
      m_res[tag] = 1'b1;
      m_at[tag]  = t;
      m_atg[tag] = tg;
    end
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=still running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [TAGW-1:0] h0, ta, tb, tc, tg;
    rst_ni = 1'b0;
    bus.alloc_valid_i = 1'b0; bus.alloc_pc_i = '0; bus.alloc_pred_taken_i = 1'b0;
    bus.alloc_pred_target_i = '0; bus.res_valid_i = 1'b0; bus.res_tag_i = '0;
    bus.res_taken_i = 1'b0; bus.res_target_i = '0;
    model_reset();
    idle(2);
    check("rst_count", bus.count_o, 0);
    check("rst_ready", bus.alloc_ready_o, 1);
    check("rst_tag", bus.alloc_tag_o, 0);
    check("rst_ex_valid", bus.ex_br_valid_o, 0);
    check("rst_flush", bus.flush_o, 0);
    check("rst_redirect", bus.redirect_pc_o, 0);
    rst_ni = 1'b1;
    idle(1);

    // correctly predicted taken branch
    alloc_ok(32'h100, 1'b1, 32'h140);
    check("count_one", bus.count_o, 1);
    resolve(0, 1'b1, 32'h140);
    cyc();
    check("pulse_hi", bus.ex_br_valid_o, 1);
    check("no_flush", bus.flush_o, 0);
    cyc();
    check("pulse_lo", bus.ex_br_valid_o, 0);
    check("count_zero", bus.count_o, 0);

    // mispredicted not-taken
    alloc_ok(32'h200, 1'b1, 32'h180);
    resolve(m_head, 1'b0, 32'h0);
    cyc();
    check("flush_hi", bus.flush_o, 1);
    check("flush_redirect", bus.redirect_pc_o, 32'h204);
    check("flush_count", bus.count_o, 0);
    cyc();
    check("flush_lo", bus.flush_o, 0);
    check("ready_after_flush", bus.alloc_ready_o, 1);

    // fill, overflow attempt, out-of-order resolve
    h0 = m_head;
    for (int i = 0; i < DEPTH; i++) alloc_ok(32'h1000 + i*4, 1'b0, 32'h1004 + i*4);
    check("full_ready", bus.alloc_ready_o, 0);
    check("full_count", bus.count_o, 8);
    bus.alloc_valid_i = 1'b1; bus.alloc_pc_i = 32'hbad0;
    cyc();
    bus.alloc_valid_i = 1'b0;
    check("overflow_count", bus.count_o, 8);
    check("overflow_tag", bus.alloc_tag_o, m_tail);
    resolve(h0 + 3'd1, 1'b0, 32'h0);
    idle(3);
    check("no_early_commit", bus.count_o, 8);
    resolve(h0, 1'b0, 32'h0);
    cyc();
    check("commit0", bus.ex_br_valid_o, 1);
    cyc();
    check("commit1", bus.ex_br_valid_o, 1);
    check("commit1_addr", bus.ex_br_instr_addr_o, 32'h1004);
    for (int i = 2; i < DEPTH; i++) resolve(h0 + 3'(i), 1'b0, 32'h0);
    idle(3);
    check("drained_count", bus.count_o, m_count);

    // middle branch mispredicts; youngest resolved on the wrong path
    ta = m_tail; alloc_ok(32'h300, 1'b1, 32'h340);
    tb = m_tail; alloc_ok(32'h304, 1'b0, 32'h308);
    tc = m_tail; alloc_ok(32'h308, 1'b1, 32'h400);
    resolve(ta, 1'b1, 32'h340);
    resolve(tb, 1'b1, 32'h500);
    idle(3);
    resolve(tc, 1'b1, 32'h400);
    idle(3);
    check("wrongpath_count", bus.count_o, 0);

    // streaming alloc/resolve with tag wrap and alloc+commit overlap
    for (int i = 0; i < 20; i++) begin
      tg = m_tail;
      alloc_ok(32'h2000 + i*8, i[0], 32'h2040 + i*8);
      check("overlap_count", bus.count_o, 1);
      resolve(tg, i[0], 32'h2040 + i*8);
    end
    idle(3);
    check("stream_count", bus.count_o, 0);

    // reset with in-flight entries
    for (int i = 0; i < 4; i++) alloc_ok(32'h3000 + i*4, 1'b0, 32'h3004 + i*4);
    resolve(m_head + 3'd1, 1'b0, 32'h0);
    resolve(m_head + 3'd2, 1'b0, 32'h0);
    check("pre_rst_count", bus.count_o, 4);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_count", bus.count_o, 0);
    check("arst_ready", bus.alloc_ready_o, 1);
    check("arst_tag", bus.alloc_tag_o, 0);
    check("arst_ex_valid", bus.ex_br_valid_o, 0);
    check("arst_addr", bus.ex_br_instr_addr_o, 0);
    check("arst_taken", bus.ex_br_taken_o, 0);
    check("arst_flush", bus.flush_o, 0);
    check("arst_redirect", bus.redirect_pc_o, 0);
    model_reset();
    cyc();
    rst_ni = 1'b1;
    idle(6);
    check("post_rst_count", bus.count_o, 0);

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL pending_updates observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
